// File: rtl/baser_257b_transcoder.sv
// ---------------------------------------------------------------------------
// baser_257b_transcoder
//
// Transmit-side 256b/257b transcoder. Four consecutive 66b BASE-R blocks are
// collected and packed into one 257b transcoded block. Each group is
// classified as all-data, mixed-control or error.
//
// Ports:
//   clk               single clock
//   i_rst             synchronous active-high reset
//   i_tx_coded        66b block, [1:0] sync header, [65:2] payload
//   i_valid/o_ready   input beat handshake
//   o_tx_xcoded       257b transcoded block
//   o_valid/i_ready   output handshake
//   o_block_count     groups formed
//   o_data_count      all-data groups
//   o_ctrl_count      groups with at least one control block
//   o_inv_block_count error groups
//
// Configuration:
//   BASER_257B_TX_COUNTERS_EN  defined   -> the four group counters are built
//                              undefined -> counter outputs tied to zero
// ---------------------------------------------------------------------------
module baser_257b_transcoder #(
    parameter int DATA_WIDTH    = 64,
    parameter int HDR_WIDTH     = 2,
    parameter int FRAME_WIDTH   = DATA_WIDTH + HDR_WIDTH,
    parameter int TC_DATA_WIDTH = 4 * DATA_WIDTH,
    parameter int TC_WIDTH      = TC_DATA_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [FRAME_WIDTH-1:0] i_tx_coded,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [TC_WIDTH-1:0]    o_tx_xcoded,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [31:0]            o_block_count,
    output logic [31:0]            o_data_count,
    output logic [31:0]            o_ctrl_count,
    output logic [31:0]            o_inv_block_count
);

    localparam int DW = DATA_WIDTH;

    // Legal 64b/66b control block type field values.
    function automatic logic type_ok(input logic [7:0] t);
        case (t)
            8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
            8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: type_ok = 1'b1;
            default:                                          type_ok = 1'b0;
        endcase
    endfunction

    logic [1:0]             slot_q, slot_d;
    logic [FRAME_WIDTH-1:0] slot_reg_q [0:2];
    logic [TC_WIDTH-1:0]    xcoded_q, xcoded_d;
    logic                   valid_q, valid_d;

    logic                   accept;
    logic                   load;

    logic [FRAME_WIDTH-1:0] blk     [0:3];
    logic [DATA_WIDTH-1:0]  pay     [0:3];
    logic [3:0]             is_data;
    logic [3:0]             is_ctrl;
    logic                   all_data;
    logic                   any_invalid;
    logic [1:0]             first_ctrl;
    logic [TC_DATA_WIDTH-1:0] payload_cat;
    logic [TC_DATA_WIDTH-5:0] mixed_body;
    logic [TC_WIDTH-1:0]    enc;

    // The slot-3 beat is never stored: it is encoded straight from the input
    // together with the three stored beats.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        if (gi == 3) begin : g_live
            assign blk[gi] = i_tx_coded;
        end else begin : g_stored
            assign blk[gi] = slot_reg_q[gi];
        end
        assign pay[gi]     = blk[gi][FRAME_WIDTH-1:HDR_WIDTH];
        assign is_data[gi] = (blk[gi][HDR_WIDTH-1:0] == 2'b01);
        assign is_ctrl[gi] = (blk[gi][HDR_WIDTH-1:0] == 2'b10) && type_ok(pay[gi][7:0]);
    end

    assign payload_cat = {pay[3], pay[2], pay[1], pay[0]};
    assign all_data    = &is_data;
    assign any_invalid = |(~(is_data | is_ctrl));

    always_comb begin
        first_ctrl = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (is_ctrl[i]) first_ctrl = 2'(i);
        end
    end

    // Mixed packing: the payload stream with the high nibble of the first
    // control block's type byte cut out (bits 4..7 of that block).
    always_comb begin
        case (first_ctrl)
            2'd0:    mixed_body = {payload_cat[TC_DATA_WIDTH-1:8],        payload_cat[3:0]};
            2'd1:    mixed_body = {payload_cat[TC_DATA_WIDTH-1:DW+8],     payload_cat[DW+3:0]};
            2'd2:    mixed_body = {payload_cat[TC_DATA_WIDTH-1:2*DW+8],   payload_cat[2*DW+3:0]};
            default: mixed_body = {payload_cat[TC_DATA_WIDTH-1:3*DW+8],   payload_cat[3*DW+3:0]};
        endcase
    end

    // Error groups carry mask 4'b1111, which a receiver can never accept as a
    // mixed group since at least one slot would have to be control.
    always_comb begin
        enc = '0;
        if (all_data) begin
            enc = {payload_cat, 1'b1};
        end else if (any_invalid) begin
            enc = {payload_cat[TC_DATA_WIDTH-5:0], 4'b1111, 1'b0};
        end else begin
            enc = {mixed_body, is_data, 1'b0};
        end
    end

    // Only the slot-3 beat can stall, and only behind a held output.
    assign o_ready = !((slot_q == 2'd3) && valid_q && !i_ready);
    assign accept  = i_valid && o_ready;
    assign load    = accept && (slot_q == 2'd3);

    always_comb begin
        slot_d   = slot_q;
        valid_d  = valid_q;
        xcoded_d = xcoded_q;
        if (accept) slot_d = slot_q + 2'd1;
        if (load) begin
            valid_d  = 1'b1;
            xcoded_d = enc;
        end else if (i_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            slot_q   <= 2'd0;
            valid_q  <= 1'b0;
            xcoded_q <= '0;
        end else begin
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            xcoded_q <= xcoded_d;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_store
        always_ff @(posedge clk) begin
            if (i_rst) begin
                slot_reg_q[gi] <= '0;
            end else if (accept && (slot_q == 2'(gi))) begin
                slot_reg_q[gi] <= i_tx_coded;
            end
        end
    end

    assign o_tx_xcoded = xcoded_q;
    assign o_valid     = valid_q;

`ifdef BASER_257B_TX_COUNTERS_EN
    logic [31:0] block_cnt_q, data_cnt_q, ctrl_cnt_q, inv_cnt_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            block_cnt_q <= 32'd0;
            data_cnt_q  <= 32'd0;
            ctrl_cnt_q  <= 32'd0;
            inv_cnt_q   <= 32'd0;
        end else if (load) begin
            block_cnt_q <= block_cnt_q + 32'd1;
            if (all_data)         data_cnt_q <= data_cnt_q + 32'd1;
            else if (any_invalid) inv_cnt_q  <= inv_cnt_q + 32'd1;
            else                  ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
        end
    end

    assign o_block_count     = block_cnt_q;
    assign o_data_count      = data_cnt_q;
    assign o_ctrl_count      = ctrl_cnt_q;
    assign o_inv_block_count = inv_cnt_q;
`else
    assign o_block_count     = 32'd0;
    assign o_data_count      = 32'd0;
    assign o_ctrl_count      = 32'd0;
    assign o_inv_block_count = 32'd0;
`endif

endmodule

// File: doc/baser_257b_transcoder.md
# baser_257b_transcoder

Transmit-side 256b/257b transcoder. It collects four consecutive 66b BASE-R blocks from the 64b/66b encoder and packs them into one 257b transcoded block. Each group is classified as all-data, mixed-control or error, and the block keeps running group counters. It sits directly upstream of the 257b receive checker: its `o_tx_xcoded` output is the stimulus format that checker decodes.

## Interface
Parameters:
- `DATA_WIDTH`, default 64: 66b block payload width.
- `HDR_WIDTH`, default 2: sync header width.
- `FRAME_WIDTH`, default `DATA_WIDTH+HDR_WIDTH`: 66b block width.
- `TC_DATA_WIDTH`, default `4*DATA_WIDTH`: transcoded payload width.
- `TC_WIDTH`, default `TC_DATA_WIDTH+1`: 257b block width.

Ports:
- `clk`  in  1: single clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_tx_coded`  in  `FRAME_WIDTH`: 66b block. Bits [1:0] are the sync header; bits [65:2] are the payload.
- `i_valid`  in  1: `i_tx_coded` is valid.
- `o_ready`  out  1: block accepts a beat.
- `o_tx_xcoded`  out  `TC_WIDTH`: 257b transcoded block.
- `o_valid`  out  1: `o_tx_xcoded` is valid.
- `i_ready`  in  1: downstream accepts the output.
- `o_block_count`  out  32: groups formed.
- `o_data_count`  out  32: all-data groups.
- `o_ctrl_count`  out  32: groups with at least one control block.
- `o_inv_block_count`  out  32: error groups.

## Operation
**Beat acceptance**
- A beat is accepted when `i_valid && o_ready`.
- A 2-bit slot index (0..3) tracks the position in the group; it wraps 3→0.
- Accepted beats are stored in slot registers 0..2. Slot 3 is encoded directly from `i_tx_coded`.

**Header and block-type classification**
- Header 2'b01 = data; 2'b10 = control; 2'b00 or 2'b11 = invalid.
- Valid control block types (payload[7:0]): 0x1E, 0x2D, 0x33, 0x4B, 0x55, 0x66, 0x78, 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF. Any other type is invalid.

**Encoding, applied on acceptance of the slot-3 beat**
- **All-data group:**
  - bit0 = 1.
  - bits [256:1] = payloads of slots 0..3, slot 0 in the LSBs.
- **Mixed group (≥1 control block, none invalid):**
  - bit0 = 0.
  - bits [4:1] = data mask; bit i+1 = 1 when slot i is data.
  - Payloads are then packed from bit 5 upward in slot order.
  - The first control block (lowest slot) contributes its type low nibble (payload[3:0]) followed by payload[63:8], 60 bits in total. The type high nibble is dropped.
  - Every other block contributes its full 64-bit payload.
- **Error group (any invalid header or type):**
  - bit0 = 0 and bits [4:1] = 4'b1111, which is guaranteed invalid at the receiver.
  - bits [256:5] = payloads of slots 0..3 concatenated, truncated to 252 bits.

**Counters**
- On each group formation, `o_block_count` increments by 1.
- Exactly one of `o_data_count`, `o_ctrl_count` or `o_inv_block_count` increments, according to the group class.
- All counters wrap at 2^32.

**Output register**
- The output register loads the encoded group and sets `o_valid`.
- `o_valid` clears when `i_ready` is high and no new group loads in the same cycle.

**Backpressure**
- `o_ready = !(slot==3 && o_valid && !i_ready)`.
- Slots 0..2 are always accepted.
- The slot-3 beat is accepted only if the output register is empty or is draining in the same cycle.

## Timing
- **Reset:** `o_valid`=0, `o_tx_xcoded`=0, slot index=0, all counters=0, slot registers=0. `o_ready`=1 in the first cycle after reset.
- **Reset mid-group:** partial beats are discarded and the next accepted beat is slot 0. Reset mid-stall drops the pending output.
- **Latency:** the slot-3 beat is accepted at edge N. `o_tx_xcoded`/`o_valid` and the counters update at edge N. Both are visible during cycle N+1.
- **Simultaneous drain and load** (`o_valid && i_ready` while slot 3 is accepted): the new group replaces the old one and `o_valid` stays 1. No bubble and no loss.
- **Output stability:** while `o_valid && !i_ready`, `o_tx_xcoded` holds stable.
- **Throughput:** the sustained rate is 1 group per 4 accepted beats.

## Configuration
- `BASER_257B_TX_COUNTERS_EN` defined: the four counters are implemented as specified.
- `BASER_257B_TX_COUNTERS_EN` undefined: no counter registers are built, and all four counter outputs are tied to 32'd0. Encoding and handshake behaviour are unchanged.

## Test plan
- **All-data group.** Four data blocks with payload {8{8'hAA}}, header 2'b01, `i_ready`=1.
  - Required: `o_tx_xcoded` = {{32{8'hAA}},1'b1}; counts block=1, data=1.
- **Start block in slot 0.** Slot 0 is control type 0x78 with payload[63:8]={7{8'hAA}}; slots 1..3 are data 0xAA.
  - Required: bit0=0, [4:1]=4'b1110, [8:5]=4'h8, [64:9]={7{8'hAA}}, [256:65]={24{8'hAA}}; ctrl=1.
- **Mixed C/D group.** Slots 0 and 2 data; slot 1 is type 0xFF; slot 3 is type 0x87.
  - Required: [4:1]=4'b0101, [72:69]=4'hF, [200:193]=8'h87; ctrl=1.
- **Invalid input.** Slot 2 header 2'b11; separately, slot 1 is type 0x5A.
  - Required for each: [4:1]=4'b1111, bit0=0; `o_inv_block_count` increments each time.
- **Backpressure.** Hold `i_ready`=0 while a second group fills.
  - Required: `o_ready`=0 at slot 3; the first output is held.
  - Raise `i_ready`: the slot-3 beat is accepted the same cycle, the new group appears next cycle, and no group is lost.
- **Reset mid-group.** Assert `i_rst` after 2 beats, then send 4 beats.
  - Required: exactly one group, built only from the 4 post-reset beats; block count=1.
